sha256_digest_byte_tx: RTL and testbench
========================================

Name: sha256_digest_byte_tx

Overview:
Transmit side of the 8-bit byte interface used by the SHA-256 core.
- Accepts one 256-bit digest from the hash core in a single valid/ready handshake.
- Streams the digest out as 32 bytes, most significant byte first (standard SHA-256 output order), over a valid/ready byte handshake.
- Sits between the hash core's final digest register and the downstream byte consumer (host or output register stage).

Parameters:
DATA_WIDTH, 8, width of one output beat in bits.
DIGEST_WIDTH, 256, width of the digest input in bits; must be a multiple of DATA_WIDTH.
NUM_BYTES, DIGEST_WIDTH/DATA_WIDTH (32), beats per digest; derived, not overridden.

Ports:
clock  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
digest_in  input  DIGEST_WIDTH  digest word; bits [255:248] are the first byte sent.
digest_valid  input  1  digest_in is valid this cycle.
digest_ready  output  1  block can accept a digest.
byte_out  output  DATA_WIDTH  current output byte.
byte_valid  output  1  byte_out is valid.
byte_ready  input  1  consumer accepts byte_out this cycle.
byte_last  output  1  byte_out is the final byte (index NUM_BYTES-1) of the digest.
byte_index  output  5  index of the current byte, 0..NUM_BYTES-1.
busy  output  1  a digest is being streamed.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: digest_ready=0, byte_valid=0, byte_last=0, byte_out=0, byte_index=0, busy=0; state=IDLE; shift register cleared.
- After reset: digest_ready rises on the first posedge with reset low.

State IDLE:
- digest_ready=1, byte_valid=0.
- When digest_valid and digest_ready are both high at a posedge:
  - load digest_in into the shift register;
  - set byte_index=0, byte_valid=1, busy=1, digest_ready=0;
  - go to SEND.
- First byte is visible the cycle after acceptance (latency 1).

State SEND:
- byte_out = shift register [DIGEST_WIDTH-1 -: DATA_WIDTH].
- byte_last = (byte_index == NUM_BYTES-1).
- Transfer occurs when byte_valid and byte_ready are both high at a posedge.
- Non-last transfer: shift register shifts left by DATA_WIDTH (zero fill); byte_index increments.
- Last transfer:
  - byte_valid=0, byte_last=0, busy=0, byte_index=0, digest_ready=1;
  - go to IDLE.
- Backpressure: while byte_ready=0, byte_out, byte_index and byte_last hold stable; byte_valid never drops mid-digest.
- digest_valid is ignored in SEND (digest_ready=0), so no digest is lost or overwritten.

Boundary conditions:
- Throughput without the optional feature: 32 byte cycles plus 1 idle cycle per digest. The next digest is accepted no earlier than 1 cycle after the last-byte transfer.
- byte_index never exceeds NUM_BYTES-1; there is no wrap beyond it.
- Reset in mid-stream: aborts immediately at that posedge. All outputs take reset values; the partial digest is discarded.
- digest_valid high during reset: ignored.

Optional Feature:
Macro DIGEST_TX_BACK2BACK_EN.
- Defined:
  - digest_ready is also high in SEND while byte_last=1.
  - If the last-byte transfer and a digest handshake occur at the same posedge, load the new digest, set byte_index=0, keep byte_valid=1, stay in SEND.
  - Zero-bubble streaming: 32 cycles per digest.
  - If no digest arrives at that edge, behaviour is as without the feature.
- Undefined: digest_ready=0 throughout SEND; the 1-cycle bubble is mandatory.

Test Plan:
1. Reset, then digest_in=SHA-256("abc")=256'hba7816bf...f20015ad with digest_valid for 1 cycle, byte_ready=1 -> bytes BA,78,16,BF,...,15,AD on 32 consecutive cycles; byte_last only with AD (byte_index=31); digest_ready=1 the cycle after.
2. Same digest, byte_ready toggling 1,0,0,1,... -> each byte held stable while byte_ready=0; exact 32-byte sequence; no duplicates or drops.
3. digest_valid held high with a second digest 256'h0123...cdef during SEND -> ignored until IDLE; then accepted; first byte 0x01 one cycle after acceptance.
4. Assert reset after byte_index=10 -> next cycle byte_valid=0, busy=0, byte_out=0; digest_ready=1 after reset release; fresh digest streams from byte 0.
5. With DIGEST_TX_BACK2BACK_EN, two digests offered back-to-back, byte_ready=1 -> 64 consecutive valid bytes, no gap; byte_last on cycles 32 and 64.
6. Without the macro, same stimulus as 5 -> exactly one byte_valid=0 cycle between the two digests.

Source files
------------

// File: rtl/sha256_digest_byte_tx.sv
// SHA-256 digest byte transmitter: takes one 256-bit digest, streams it MSB byte first.
// Define DIGEST_TX_BACK2BACK_EN to accept the next digest on the last-byte transfer (no bubble).
module sha256_digest_byte_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int DIGEST_WIDTH = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DIGEST_WIDTH-1:0] digest_in,
  input  logic                    digest_valid,
  output logic                    digest_ready,
  output logic [DATA_WIDTH-1:0]   byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_last,
  output logic [4:0]              byte_index,
  output logic                    busy
);

  localparam int         NUM_BYTES  = DIGEST_WIDTH / DATA_WIDTH;
  localparam logic [4:0] LAST_INDEX = 5'(NUM_BYTES - 1);
`ifdef DIGEST_TX_BACK2BACK_EN
  localparam logic BACK2BACK = 1'b1;
`else
  localparam logic BACK2BACK = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_reg, state_next;
  logic [DIGEST_WIDTH-1:0] shift_reg, shift_next;
  logic [4:0]              index_reg, index_next;
  logic                    ready_reg, ready_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic                    busy_reg, busy_next;
  logic                    load;
  logic                    xfer;

  assign load = digest_valid & ready_reg;
  assign xfer = valid_reg & byte_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    index_next = index_reg;
    ready_next = ready_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    unique case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
        index_next = 5'd0;
        if (load) begin
          state_next = SEND;
          shift_next = digest_in;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          ready_next = 1'b0;
          last_next  = (LAST_INDEX == 5'd0);
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_reg) begin
            // ready_reg is only high here when back-to-back loading is enabled
            if (BACK2BACK && load) begin
              shift_next = digest_in;
              index_next = 5'd0;
              last_next  = (LAST_INDEX == 5'd0);
              ready_next = (LAST_INDEX == 5'd0);
            end else begin
              state_next = IDLE;
              shift_next = shift_reg << DATA_WIDTH;
              valid_next = 1'b0;
              last_next  = 1'b0;
              busy_next  = 1'b0;
              index_next = 5'd0;
              ready_next = 1'b1;
            end
          end else begin
            shift_next = shift_reg << DATA_WIDTH;
            index_next = index_reg + 5'd1;
            last_next  = ((index_reg + 5'd1) == LAST_INDEX);
            ready_next = BACK2BACK & ((index_reg + 5'd1) == LAST_INDEX);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      index_reg <= 5'd0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      index_reg <= index_next;
      ready_reg <= ready_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
    end
  end

  assign digest_ready = ready_reg;
  assign byte_out     = shift_reg[DIGEST_WIDTH-1 -: DATA_WIDTH];
  assign byte_valid   = valid_reg;
  assign byte_last    = last_reg;
  assign byte_index   = index_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_sha256_digest_byte_tx.sv
// Randomised bench for sha256_digest_byte_tx against a digest/index reference model.
// Honours DIGEST_TX_BACK2BACK_EN for the expected inter-digest gap.
module tb_sha256_digest_byte_tx;

`ifdef DIGEST_TX_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D2  = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] digest_in = '0;
  logic         digest_valid = 1'b0;
  logic         digest_ready;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready = 1'b0;
  logic         byte_last;
  logic [4:0]   byte_index;
  logic         busy;

  sha256_digest_byte_tx dut (
    .clock(clock), .reset(reset), .digest_in(digest_in), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .byte_index(byte_index), .busy(busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_mode = 0;
  bit checking = 1'b0;

  // reference model: which digest is streaming and which byte of it is on the wire
  bit           m_busy = 1'b0;
  bit           m_ready = 1'b0;
  int           m_idx = 0;
  logic [255:0] m_dig = '0;
  logic [7:0]   exp_byte;

  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  bit         rx_last[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [255:0] rx_word(int base);
    logic [255:0] w = '0;
    if (rx_q.size() < base + 32) return '0;
    for (int i = 0; i < 32; i++) w = {w[247:0], rx_q[base+i]};
    return w;
  endfunction

  // compare then advance the model using the inputs the next posedge will see
  initial begin
    forever begin
      @(negedge clock);
      if (checking) begin
        exp_byte = m_busy ? 8'(m_dig >> (8 * (31 - m_idx))) : 8'h00;
        chk("digest_ready", 64'(digest_ready), 64'(m_ready));
        chk("byte_valid", 64'(byte_valid), 64'(m_busy));
        chk("byte_out", 64'(byte_out), 64'(exp_byte));
        chk("byte_last", 64'(byte_last), 64'(m_busy && m_idx == 31));
        chk("byte_index", 64'(byte_index), m_busy ? 64'(m_idx) : 64'd0);
        chk("busy", 64'(busy), 64'(m_busy));
        if (!reset && byte_valid && byte_ready) begin
          rx_q.push_back(byte_out);
          rx_cyc.push_back(cyc);
          rx_last.push_back(byte_last);
        end
      end
      if (reset) begin
        m_busy = 1'b0; m_idx = 0; m_ready = 1'b0;
      end else if (!m_busy) begin
        if (m_ready && digest_valid) begin
          m_dig = digest_in; m_busy = 1'b1; m_idx = 0; m_ready = 1'b0;
          $display("digest accepted at cycle %0d: %h", cyc, digest_in);
        end else begin
          m_ready = 1'b1;
        end
      end else if (byte_ready) begin
        if (m_idx == 31) begin
          if (B2B && digest_valid) begin
            m_dig = digest_in; m_idx = 0; m_ready = 1'b0;
            $display("digest accepted back-to-back at cycle %0d: %h", cyc, digest_in);
          end else begin
            m_busy = 1'b0; m_idx = 0; m_ready = 1'b1;
          end
        end else begin
          m_idx++;
          m_ready = B2B && (m_idx == 31);
        end
      end
    end
  end

  // byte_ready pattern: 0 always high, 1 repeating 1,0,0, 2 random
  initial begin
    int ph = 0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: byte_ready = 1'b1;
        1: begin byte_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_digest(input logic [255:0] d, input bit hold);
    bit ok = 1'b0;
    digest_in = d;
    digest_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (digest_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    if (!hold) digest_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 2000 && rx_q.size() < n; i++) @(negedge clock);
    chk("rx_count_reached", 64'(rx_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      if (digest_ready && !byte_valid) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_cyc.delete(); rx_last.delete();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_pair(input logic [255:0] a, input logic [255:0] b);
    int lasts = 0;
    ready_mode = 0;
    clear_rx();
    send_digest(a, 1'b1);
    send_digest(b, 1'b0);
    wait_rx(64);
    chk("pair_first_word", 64'(rx_word(0) == a), 64'd1);
    chk("pair_second_word", 64'(rx_word(32) == b), 64'd1);
    if (rx_q.size() >= 64) begin
      chk("pair_gap", 64'(rx_cyc[32] - rx_cyc[31] - 1), B2B ? 64'd0 : 64'd1);
      chk("pair_first_half_back", 64'(rx_cyc[31] - rx_cyc[0]), 64'd31);
      for (int i = 0; i < 64; i++) lasts += int'(rx_last[i]);
      chk("pair_last_flags", {62'd0, rx_last[63], rx_last[31]}, 64'd3);
      chk("pair_last_count", 64'(lasts), 64'd2);
    end
    wait_idle();
  endtask

  initial begin
    logic [255:0] d;
    bit ok;
    @(posedge clock); #1;
    checking = 1'b1;
    digest_valid = 1'b1;
    digest_in = D2;
    @(negedge clock);
    chk("ready_in_reset", 64'(digest_ready), 64'd0);
    @(posedge clock); #1;
    digest_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("ready_after_reset", 64'(digest_ready), 64'd1);
    @(posedge clock); #1;

    // full-rate "abc" digest
    ready_mode = 0;
    clear_rx();
    send_digest(ABC, 1'b0);
    wait_rx(32);
    if (rx_q.size() >= 32) begin
      chk("abc_byte0", 64'(rx_q[0]), 64'hBA);
      chk("abc_byte1", 64'(rx_q[1]), 64'h78);
      chk("abc_byte31", 64'(rx_q[31]), 64'hAD);
      chk("abc_word", 64'(rx_word(0) == ABC), 64'd1);
      chk("abc_consecutive", 64'(rx_cyc[31] - rx_cyc[0]), 64'd31);
      chk("abc_last_on_31", {62'd0, rx_last[30], rx_last[31]}, 64'd1);
    end
    wait_idle();

    // backpressure 1,0,0
    ready_mode = 1;
    clear_rx();
    send_digest(ABC, 1'b0);
    wait_rx(32);
    wait_idle();
    chk("bp_count", 64'(rx_q.size()), 64'd32);
    chk("bp_word", 64'(rx_word(0) == ABC), 64'd1);

    // second digest held valid during SEND
    run_pair(ABC, D2);
    if (rx_q.size() >= 33) chk("d2_first_byte", 64'(rx_q[32]), 64'h01);

    // reset mid-stream
    ready_mode = 0;
    clear_rx();
    send_digest(rand256(), 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (byte_index == 5'd10) ok = 1'b1;
    end
    chk("reached_index10", 64'(ok), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_valid", 64'(byte_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_byte", 64'(byte_out), 64'd0);
    @(posedge clock); #1;
    clear_rx();
    d = rand256();
    send_digest(d, 1'b0);
    wait_rx(32);
    chk("post_reset_word", 64'(rx_word(0) == d), 64'd1);
    wait_idle();

    // random digests under random backpressure
    for (int n = 0; n < 5; n++) begin
      ready_mode = 2;
      clear_rx();
      d = rand256();
      send_digest(d, 1'b0);
      wait_rx(32);
      chk("rand_word", 64'(rx_word(0) == d), 64'd1);
      wait_idle();
    end

    // two digests offered back-to-back
    run_pair(rand256(), rand256());

    repeat (3) @(posedge clock);
    @(negedge clock);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
